// File: rtl/activation_unit.sv
// Streaming element-wise activation (pass / ReLU / clip / leaky) with a start/busy/done vector sequencer.
// Define ACTIVATION_LEAKY_EN to build the leaky-ReLU shifter; otherwise mode 3 falls back to ReLU.
module activation_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16,
    parameter int LENGTH     = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [DATA_WIDTH-1:0]       clip_val,
    input  logic [2:0]                  leak_shift,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int BEATS = LENGTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [1:0]                   mode_q, mode_d;
    logic signed [DATA_WIDTH-1:0] clip_q, clip_d;
    logic [CNT_W-1:0]             in_count_q, in_count_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [LANES*DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [LANES*DATA_WIDTH-1:0]  act_data;
    logic signed [DATA_WIDTH-1:0] clip_pos;
    logic                         in_fire;
    logic                         out_fire;

`ifdef ACTIVATION_LEAKY_EN
    logic [2:0] shift_q, shift_d;

    function automatic logic [DATA_WIDTH-1:0] act_lane(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [1:0]                   m,
        input logic signed [DATA_WIDTH-1:0] c,
        input logic [2:0]                   sh
    );
        logic [DATA_WIDTH-1:0] y;
        case (m)
            2'd0:    y = x;
            2'd2:    y = x[DATA_WIDTH-1] ? '0 : ((x > c) ? c : x);
            2'd3:    y = x[DATA_WIDTH-1] ? (x >>> sh) : x;
            default: y = x[DATA_WIDTH-1] ? '0 : x;
        endcase
        return y;
    endfunction
`else
    logic unused_leak_shift;
    assign unused_leak_shift = ^leak_shift;

    // Mode 3 shares the ReLU arm when the shifter is not built.
    function automatic logic [DATA_WIDTH-1:0] act_lane(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [1:0]                   m,
        input logic signed [DATA_WIDTH-1:0] c
    );
        logic [DATA_WIDTH-1:0] y;
        case (m)
            2'd0:    y = x;
            2'd2:    y = x[DATA_WIDTH-1] ? '0 : ((x > c) ? c : x);
            default: y = x[DATA_WIDTH-1] ? '0 : x;
        endcase
        return y;
    endfunction
`endif

    // A negative clip bound collapses to zero, forcing every clipped lane to 0.
    assign clip_pos = clip_q[DATA_WIDTH-1] ? '0 : clip_q;

    assign in_ready  = (state_q == ST_RUN) && (in_count_q < BEATS_C) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    always_comb begin
        act_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef ACTIVATION_LEAKY_EN
            act_data[i*DATA_WIDTH +: DATA_WIDTH] =
                act_lane($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]), mode_q, clip_pos, shift_q);
`else
            act_data[i*DATA_WIDTH +: DATA_WIDTH] =
                act_lane($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]), mode_q, clip_pos);
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        clip_d      = clip_q;
`ifdef ACTIVATION_LEAKY_EN
        shift_d     = shift_q;
`endif
        in_count_d  = in_count_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        // Refill takes priority over drain so a simultaneous handshake keeps out_valid high.
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = act_data;
            out_last_d  = (in_count_q == LAST_C);
            in_count_d  = in_count_q + CNT_W'(1);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    mode_d      = mode;
                    clip_d      = clip_val;
`ifdef ACTIVATION_LEAKY_EN
                    shift_d     = leak_shift;
`endif
                    in_count_d  = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (out_fire && out_last_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            clip_q      <= '0;
`ifdef ACTIVATION_LEAKY_EN
            shift_q     <= '0;
`endif
            in_count_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            clip_q      <= clip_d;
`ifdef ACTIVATION_LEAKY_EN
            shift_q     <= shift_d;
`endif
            in_count_q  <= in_count_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
